// File: rtl/asc_pkg.sv
// Shared types and helpers for the two-car elevator dispatcher.
package asc_pkg;

  localparam int unsigned N_PISOS = 4;

  // Car motion encodings as reported by the car motion blocks.
  localparam logic [1:0] DIR_PARADO = 2'b00;
  localparam logic [1:0] DIR_SUBE   = 2'b01;
  localparam logic [1:0] DIR_BAJA   = 2'b10;

  typedef enum logic [1:0] {
    LIBRE      = 2'b00,
    ASIGNADO   = 2'b01,
    ATENDIENDO = 2'b10
  } estado_asc_t;

  // Nearest candidate floor to piso; returns {valid, floor}.
  // Ascending scan with strict '<' makes ties go to the lower floor.
  function automatic logic [2:0] piso_cercano(input logic [1:0]         piso,
                                              input logic [N_PISOS-1:0] cand);
    logic       hay;
    logic [1:0] mejor;
    logic [2:0] mejor_dist;
    logic [2:0] p;
    logic [2:0] f3;
    logic [2:0] d;
    hay        = 1'b0;
    mejor      = 2'd0;
    mejor_dist = 3'd7;
    p          = {1'b0, piso};
    for (int f = 0; f < N_PISOS; f++) begin
      f3 = 3'(f);
      d  = (p > f3) ? (p - f3) : (f3 - p);
      if (cand[f] && (!hay || d < mejor_dist)) begin
        hay        = 1'b1;
        mejor      = 2'(f);
        mejor_dist = d;
      end
    end
    return {hay, mejor};
  endfunction

endpackage

// File: rtl/fsm_ascensor.sv
// Per-car dispatch FSM: assignment, arrival, door phase and arrival timeout.
module fsm_ascensor
  import asc_pkg::*;
#(
  parameter int unsigned              ANCHO_CONT = 26,
  parameter logic [ANCHO_CONT-1:0]    ESPERA_MAX = 26'd50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        grant,
  input  logic [1:0]  piso_elegido,
  input  logic [1:0]  piso,
  input  logic        puertas_abiertas,
  output estado_asc_t estado,
  output logic [1:0]  objetivo,
  output logic        limpiar,
  output logic [1:0]  destino
);

  localparam logic [ANCHO_CONT-1:0] LIMITE = ANCHO_CONT'(ESPERA_MAX - 1);

  estado_asc_t            estado_q, estado_d;
  logic [ANCHO_CONT-1:0]  cont_q, cont_d;
  logic [1:0]             objetivo_q, objetivo_d;
  logic [1:0]             destino_q, destino_d;

  // State, counter, target and destination registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= LIBRE;
      cont_q     <= '0;
      objetivo_q <= 2'b00;
      destino_q  <= 2'b00;
    end else begin
      estado_q   <= estado_d;
      cont_q     <= cont_d;
      objetivo_q <= objetivo_d;
      destino_q  <= destino_d;
    end
  end

  // Next-state logic; arrival takes priority over timeout in the same cycle.
  always_comb begin
    estado_d   = estado_q;
    cont_d     = cont_q;
    objetivo_d = objetivo_q;
    destino_d  = destino_q;
    limpiar    = 1'b0;
    unique case (estado_q)
      LIBRE: begin
        if (grant) begin
          estado_d   = ASIGNADO;
          objetivo_d = piso_elegido;
          destino_d  = piso_elegido;
          cont_d     = '0;
        end
      end
      ASIGNADO: begin
        if (piso == objetivo_q && puertas_abiertas) begin
          estado_d = ATENDIENDO;
          limpiar  = 1'b1;
        end else if (cont_q == LIMITE) begin
          // Pending bit is left set so the floor is offered again.
          estado_d = LIBRE;
        end else if (cont_q != '1) begin
          cont_d = cont_q + 1'b1;
        end
      end
      ATENDIENDO: begin
        if (!puertas_abiertas) estado_d = LIBRE;
      end
      default: estado_d = LIBRE;
    endcase
  end

  assign estado   = estado_q;
  assign objetivo = objetivo_q;
  assign destino  = destino_q;

endmodule

// File: rtl/controlador_ascensores.sv
// Two-car dispatcher: latches hall calls and assigns each to the nearest free car.
module controlador_ascensores
  import asc_pkg::*;
#(
  parameter int unsigned           ANCHO_CONT = 26,
  parameter logic [ANCHO_CONT-1:0] ESPERA_MAX = 26'd50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PISOS-1:0] llamada,
  input  logic [1:0]         piso_asc_1,
  input  logic [1:0]         direccion_asc_1,
  input  logic               puertas_abiertas_asc_1,
  input  logic [1:0]         piso_asc_2,
  input  logic [1:0]         direccion_asc_2,
  input  logic               puertas_abiertas_asc_2,
  output logic [1:0]         destino_asc_1,
  output logic [1:0]         destino_asc_2,
  output logic [N_PISOS-1:0] pendientes,
  output logic               ocupado_asc_1,
  output logic               ocupado_asc_2
);

  estado_asc_t        estado_1, estado_2;
  logic [1:0]         objetivo_1, objetivo_2;
  logic               limpiar_1, limpiar_2;
  logic [N_PISOS-1:0] pend_q, pend_d;
  logic [N_PISOS-1:0] cand, cand_2;
  logic [2:0]         sel_1, sel_2;
  logic               grant_1, grant_2;

  // Direction is informational only.
  logic unused_dir;
  assign unused_dir = ^{direccion_asc_1, direccion_asc_2};

  // Pending calls: absorb calls at a car already open on that floor; clear wins over set.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < N_PISOS; i++) begin
      if (llamada[i] &&
          !((piso_asc_1 == 2'(i) && puertas_abiertas_asc_1) ||
            (piso_asc_2 == 2'(i) && puertas_abiertas_asc_2))) begin
        pend_d[i] = 1'b1;
      end
      if ((limpiar_1 && objetivo_1 == 2'(i)) || (limpiar_2 && objetivo_2 == 2'(i))) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  // Pending-call register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // Candidate masking and arbitration; car 1 chooses before car 2.
  always_comb begin
    cand = pend_q;
    for (int i = 0; i < N_PISOS; i++) begin
      if ((estado_1 != LIBRE && objetivo_1 == 2'(i)) ||
          (estado_2 != LIBRE && objetivo_2 == 2'(i))) begin
        cand[i] = 1'b0;
      end
    end
    sel_1   = piso_cercano(piso_asc_1, cand);
    grant_1 = (estado_1 == LIBRE) && sel_1[2];
    cand_2  = cand;
    if (grant_1) cand_2[sel_1[1:0]] = 1'b0;
    sel_2   = piso_cercano(piso_asc_2, cand_2);
    grant_2 = (estado_2 == LIBRE) && sel_2[2];
  end

  fsm_ascensor #(
    .ANCHO_CONT (ANCHO_CONT),
    .ESPERA_MAX (ESPERA_MAX)
  ) u_asc_1 (
    .clk              (clk),
    .rst_n            (rst_n),
    .grant            (grant_1),
    .piso_elegido     (sel_1[1:0]),
    .piso             (piso_asc_1),
    .puertas_abiertas (puertas_abiertas_asc_1),
    .estado           (estado_1),
    .objetivo         (objetivo_1),
    .limpiar          (limpiar_1),
    .destino          (destino_asc_1)
  );

  fsm_ascensor #(
    .ANCHO_CONT (ANCHO_CONT),
    .ESPERA_MAX (ESPERA_MAX)
  ) u_asc_2 (
    .clk              (clk),
    .rst_n            (rst_n),
    .grant            (grant_2),
    .piso_elegido     (sel_2[1:0]),
    .piso             (piso_asc_2),
    .puertas_abiertas (puertas_abiertas_asc_2),
    .estado           (estado_2),
    .objetivo         (objetivo_2),
    .limpiar          (limpiar_2),
    .destino          (destino_asc_2)
  );

  assign pendientes    = pend_q;
  assign ocupado_asc_1 = (estado_1 != LIBRE);
  assign ocupado_asc_2 = (estado_2 != LIBRE);

endmodule

// File: tb/tb_controlador_ascensores.sv
// Scoreboard bench for the elevator dispatcher (short timeout of 8 cycles).
module tb_controlador_ascensores;

  logic       clk;
  logic       rst_n;
  logic [3:0] llamada;
  logic [1:0] piso_asc_1, piso_asc_2;
  logic [1:0] direccion_asc_1, direccion_asc_2;
  logic       puertas_abiertas_asc_1, puertas_abiertas_asc_2;
  logic [1:0] destino_asc_1, destino_asc_2;
  logic [3:0] pendientes;
  logic       ocupado_asc_1, ocupado_asc_2;

  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam int unsigned S_PEND = 0, S_DST1 = 1, S_DST2 = 2, S_OCU1 = 3, S_OCU2 = 4;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [3:0]  val;
  } exp_t;

  exp_t sb[$];

  controlador_ascensores #(
    .ANCHO_CONT (26),
    .ESPERA_MAX (26'd8)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .llamada                (llamada),
    .piso_asc_1             (piso_asc_1),
    .direccion_asc_1        (direccion_asc_1),
    .puertas_abiertas_asc_1 (puertas_abiertas_asc_1),
    .piso_asc_2             (piso_asc_2),
    .direccion_asc_2        (direccion_asc_2),
    .puertas_abiertas_asc_2 (puertas_abiertas_asc_2),
    .destino_asc_1          (destino_asc_1),
    .destino_asc_2          (destino_asc_2),
    .pendientes             (pendientes),
    .ocupado_asc_1          (ocupado_asc_1),
    .ocupado_asc_2          (ocupado_asc_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] observe(input int unsigned sel);
    case (sel)
      S_PEND:  return pendientes;
      S_DST1:  return {2'b00, destino_asc_1};
      S_DST2:  return {2'b00, destino_asc_2};
      S_OCU1:  return {3'b000, ocupado_asc_1};
      default: return {3'b000, ocupado_asc_2};
    endcase
  endfunction

  task automatic expect_out(input string tag, input int unsigned sel, input logic [3:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sel), e.val);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    llamada = 4'b0000;
    piso_asc_1 = 2'd0;
    piso_asc_2 = 2'd0;
    direccion_asc_1 = 2'b00;
    direccion_asc_2 = 2'b00;
    puertas_abiertas_asc_1 = 1'b0;
    puertas_abiertas_asc_2 = 1'b0;
    #3;
    expect_out("rst_pend", S_PEND, 4'b0000);
    expect_out("rst_dst1", S_DST1, 4'd0);
    expect_out("rst_dst2", S_DST2, 4'd0);
    expect_out("rst_ocu1", S_OCU1, 4'd0);
    expect_out("rst_ocu2", S_OCU2, 4'd0);
    drain();

    // 1: call latched on the first edge after release, dispatched one edge later.
    tick();
    llamada = 4'b0100;
    #2 rst_n = 1'b1;
    tick();
    llamada = 4'b0000;
    expect_out("t1_pend", S_PEND, 4'b0100);
    expect_out("t1_ocu1_early", S_OCU1, 4'd0);
    drain();
    tick();
    expect_out("t1_dst1", S_DST1, 4'd2);
    expect_out("t1_ocu1", S_OCU1, 4'd1);
    expect_out("t1_ocu2", S_OCU2, 4'd0);
    drain();

    // 2: arrival, door phase, release.
    piso_asc_1 = 2'd2;
    tick();
    expect_out("t2_pend_hold", S_PEND, 4'b0100);
    drain();
    puertas_abiertas_asc_1 = 1'b1;
    tick();
    expect_out("t2_pend_clr", S_PEND, 4'b0000);
    expect_out("t2_ocu1_serv", S_OCU1, 4'd1);
    drain();
    puertas_abiertas_asc_1 = 1'b0;
    tick();
    expect_out("t2_ocu1_free", S_OCU1, 4'd0);
    drain();

    // 3: two simultaneous calls split across cars, then a single call to car 1.
    piso_asc_1 = 2'd0;
    piso_asc_2 = 2'd3;
    llamada = 4'b1001;
    tick();
    llamada = 4'b0000;
    expect_out("t3_pend", S_PEND, 4'b1001);
    drain();
    tick();
    expect_out("t3_dst1", S_DST1, 4'd0);
    expect_out("t3_dst2", S_DST2, 4'd3);
    expect_out("t3_ocu1", S_OCU1, 4'd1);
    expect_out("t3_ocu2", S_OCU2, 4'd1);
    drain();
    puertas_abiertas_asc_1 = 1'b1;
    puertas_abiertas_asc_2 = 1'b1;
    tick();
    expect_out("t3_pend_clr", S_PEND, 4'b0000);
    drain();
    puertas_abiertas_asc_1 = 1'b0;
    puertas_abiertas_asc_2 = 1'b0;
    piso_asc_2 = 2'd0;
    tick();
    llamada = 4'b0010;
    tick();
    llamada = 4'b0000;
    tick();
    expect_out("t3b_dst1", S_DST1, 4'd1);
    expect_out("t3b_ocu1", S_OCU1, 4'd1);
    expect_out("t3b_ocu2", S_OCU2, 4'd0);
    expect_out("t3b_dst2", S_DST2, 4'd3);
    drain();
    piso_asc_1 = 2'd1;
    puertas_abiertas_asc_1 = 1'b1;
    tick();
    puertas_abiertas_asc_1 = 1'b0;
    tick();
    expect_out("t3b_done", S_PEND, 4'b0000);
    drain();

    // 4: tie at distance 1 goes to the lower floor; car 2 gets the other.
    llamada = 4'b0101;
    tick();
    llamada = 4'b0000;
    tick();
    expect_out("t4_dst1", S_DST1, 4'd0);
    expect_out("t4_dst2", S_DST2, 4'd2);
    drain();
    piso_asc_1 = 2'd0;
    piso_asc_2 = 2'd2;
    puertas_abiertas_asc_1 = 1'b1;
    puertas_abiertas_asc_2 = 1'b1;
    tick();
    puertas_abiertas_asc_1 = 1'b0;
    puertas_abiertas_asc_2 = 1'b0;
    tick();
    expect_out("t4_done", S_PEND, 4'b0000);
    drain();

    // 5: timeout after 8 cycles, call kept and reassigned.
    piso_asc_1 = 2'd0;
    piso_asc_2 = 2'd0;
    llamada = 4'b1000;
    tick();
    llamada = 4'b0000;
    tick();
    expect_out("t5_dst1", S_DST1, 4'd3);
    expect_out("t5_ocu1", S_OCU1, 4'd1);
    drain();
    for (int k = 1; k < 8; k++) tick();
    expect_out("t5_before_to", S_OCU1, 4'd1);
    drain();
    tick();
    expect_out("t5_to_free", S_OCU1, 4'd0);
    expect_out("t5_to_pend", S_PEND, 4'b1000);
    expect_out("t5_to_dst1", S_DST1, 4'd3);
    drain();
    tick();
    expect_out("t5_reasg", S_OCU1, 4'd1);
    expect_out("t5_reasg2", S_OCU2, 4'd0);
    drain();
    piso_asc_1 = 2'd3;
    puertas_abiertas_asc_1 = 1'b1;
    tick();
    puertas_abiertas_asc_1 = 1'b0;
    tick();
    expect_out("t5_done", S_PEND, 4'b0000);
    drain();

    // 6: asynchronous reset while car 2 is assigned.
    piso_asc_1 = 2'd0;
    llamada = 4'b1000;
    tick();
    llamada = 4'b0000;
    tick();
    llamada = 4'b0100;
    tick();
    llamada = 4'b0000;
    tick();
    expect_out("t6_pend", S_PEND, 4'b1100);
    expect_out("t6_dst2", S_DST2, 4'd2);
    expect_out("t6_ocu2", S_OCU2, 4'd1);
    drain();
    #2 rst_n = 1'b0;
    #1;
    expect_out("t6_rst_pend", S_PEND, 4'b0000);
    expect_out("t6_rst_dst2", S_DST2, 4'd0);
    expect_out("t6_rst_ocu2", S_OCU2, 4'd0);
    expect_out("t6_rst_ocu1", S_OCU1, 4'd0);
    expect_out("t6_rst_dst1", S_DST1, 4'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
